guess_solver: RTL
=================

// Module: guess_solver
// PURPOSE
//  Automatic player for the 6-bit number-guessing game: the guess-driving end of the game interface.
//  Issues a pseudo-random probe guess, consumes the per-bit match vector, and derives the secret.
//  It then submits the derived value as the next guess, retrying if the secret changes, and keeps win/loss statistics.
//  Sits opposite the game block; used standalone in self-play test harnesses.
// PARAMETERS
//  W          6        guess/feedback width
//  MAX_TRIES  3        guesses per round before giving up (1..15)
//  TIMEOUT    16       cycles to wait for fb_valid after guess_valid rises (>=2)
//  SEED       6'h01    nonzero LFSR reset value for probe guesses
// PORTS
//  clk          in   1  clock, rising edge
//  rst          in   1  reset, asynchronous, active-high
//  start        in   1  begin a round; ignored while busy
//  fb           in   W  per-bit match vector (1 = bit equal); all-ones = win
//  fb_valid     in   1  fb qualifier; sampled only while guess_valid=1
//  guess        out  W  current guess, stable while guess_valid=1
//  guess_valid  out  1  guess presented; held until fb accepted or timeout
//  busy         out  1  round in progress
//  solved       out  1  last round won; held until next accepted start
//  failed       out  1  last round lost; held until next accepted start
//  timed_out    out  1  last loss caused by timeout; held like failed
//  tries        out  4  guesses issued this round
//  won_cnt      out  8  rounds won, saturating at 255
//  lost_cnt     out  8  rounds lost, saturating at 255
// BEHAVIOUR
//  Reset values
//   - state IDLE; all outputs 0; lfsr=SEED; timeout counter 0.
//   - rst mid-round aborts immediately; no counter update.
//  States: IDLE, ISSUE, WAIT, GAP, DONE, FAIL.
//   - DONE/FAIL behave as IDLE for start.
//  Round start
//   - start high in IDLE/DONE/FAIL at edge E clears solved/failed/timed_out and sets busy.
//   - After E+1: guess=lfsr, guess_valid=1, tries=1; lfsr advances once per probe.
//  LFSR
//   - next = {lfsr[W-2:0], lfsr[W-1]^lfsr[W-2]} (x^6+x^5+1).
//  Feedback acceptance
//   - fb accepted at edge E when guess_valid && fb_valid.
//   - fb==all-ones: guess_valid=0, busy=0, solved=1, won_cnt++ after E.
//   - Otherwise, with tries<MAX_TRIES: est = guess ~^ fb registered at E.
//     guess_valid=0 for exactly one cycle (GAP), then guess=est, guess_valid=1, tries++ after E+1.
//   - Otherwise, with tries==MAX_TRIES: FAIL; failed=1, busy=0, lost_cnt++.
//  Timeout
//   - Counter clears on each guess_valid rise.
//   - No fb for TIMEOUT cycles: FAIL, failed=1, timed_out=1, lost_cnt++.
//   - fb_valid in the expiry cycle wins over timeout.
//  Ignored inputs
//   - fb_valid with guess_valid=0 (incl. the GAP cycle) is ignored.
//   - start while busy is ignored.
//  Boundaries
//   - fb==0 is informative (all bits mismatched): est=~guess.
//   - solved and failed are never both 1.
//   - won_cnt/lost_cnt hold at 255.
// STRUCTURE
//  - guess_pkg: GUESS_W=6, ALL_MATCH='1, state enum, LFSR taps.
//  - One sub-module, guess_lfsr (W, SEED; en, q).
//  - FSM, estimate register, timeout counter and stat counters stay in guess_solver.
// TESTING (defaults unless noted; secret modelled in bench as the game does)
//  1. Secret 101010, start.
//     Probe 000001 -> fb 010100 -> after GAP, guess 101010 -> fb 111111.
//     Expect solved=1, tries=2, won_cnt=1.
//  2. Secret 000001: probe hit -> fb 111111. Expect solved=1, tries=1.
//     Next start: probe = 000010.
//  3. Secret 101010, bench changes secret to 110011 after probe.
//     Guess 101010 -> fb 100110 -> guess 110011 -> win, tries=3.
//     Repeat with a secret change before guess 3 -> failed=1, lost_cnt=1.
//  4. Bench never asserts fb_valid.
//     Expect failed=1, timed_out=1 exactly 16 cycles after guess_valid rise.
//     fb_valid on the expiry cycle -> accepted, no timeout.
//  5. Assert rst while in WAIT: all outputs 0 asynchronously, won/lost unchanged from 0.
//     start pulses while busy and fb_valid in GAP -> no effect.
//  6. Force 255 wins -> won_cnt stays 255 on the next win; other outputs normal.

Source files
------------

// File: rtl/guess_pkg.sv
// Shared types and constants for the number-guessing solver.
package guess_pkg;

    localparam int GUESS_W = 6;
    localparam logic [GUESS_W-1:0] ALL_MATCH = '1;

    // Feedback taps, counted down from the MSB: x^6 + x^5 + 1.
    localparam int LFSR_TAP_A = 1;
    localparam int LFSR_TAP_B = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

endpackage

// File: rtl/guess_solver_if.sv
// Guess/feedback link between the solver (master) and the game (slave).
// Handshake: the master holds guess stable while guess_valid=1; the slave's fb is
// taken on any rising clk edge where guess_valid && fb_valid, otherwise fb is ignored.
interface guess_solver_if #(
    parameter int W = 6
);
    logic [W-1:0] guess;
    logic         guess_valid;
    logic [W-1:0] fb;
    logic         fb_valid;

    modport master (output guess, output guess_valid, input fb, input fb_valid);
    modport slave  (input guess, input guess_valid, output fb, output fb_valid);
endinterface

// File: rtl/guess_lfsr.sv
// Probe-guess generator: Fibonacci LFSR that advances one step per enable.
module guess_lfsr
    import guess_pkg::*;
#(
    parameter int             W    = GUESS_W,
    parameter logic [W-1:0]   SEED = W'(1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= SEED;
        end else if (i_en) begin
            r_q <= {r_q[W-2:0], r_q[W-LFSR_TAP_A] ^ r_q[W-LFSR_TAP_B]};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/guess_solver.sv
// Automatic guessing player: probes with an LFSR value, derives the secret from the
// per-bit match vector, resubmits it, and keeps saturating win/loss statistics.
module guess_solver
    import guess_pkg::*;
#(
    parameter int           W         = GUESS_W,
    parameter int           MAX_TRIES = 3,
    parameter int           TIMEOUT   = 16,
    parameter logic [W-1:0] SEED      = W'(1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    guess_solver_if.master        bus,
    output logic                  o_busy,
    output logic                  o_solved,
    output logic                  o_failed,
    output logic                  o_timed_out,
    output logic [3:0]            o_tries,
    output logic [7:0]            o_won_cnt,
    output logic [7:0]            o_lost_cnt,
    output state_t                o_state
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        r_state, w_next;
    logic [W-1:0]  r_guess, r_est, w_lfsr;
    logic          r_gv, r_busy, r_solved, r_failed, r_timed_out;
    logic [3:0]    r_tries;
    logic [7:0]    r_won, r_lost;
    logic [TW-1:0] r_tcnt;

    logic w_start_ok, w_present, w_retry, w_win, w_lose, w_expire, w_probe;

    guess_lfsr #(.W(W), .SEED(SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_probe),
        .o_q  (w_lfsr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_start_ok = 1'b0;
        w_present  = 1'b0;
        w_retry    = 1'b0;
        w_win      = 1'b0;
        w_lose     = 1'b0;
        w_expire   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (i_start) begin
                    w_next     = S_ISSUE;
                    w_start_ok = 1'b1;
                end
            end
            S_ISSUE, S_GAP: begin
                w_next    = S_WAIT;
                w_present = 1'b1;
            end
            S_WAIT: begin
                // Feedback arriving in the expiry cycle takes priority over the timeout.
                if (r_gv && bus.fb_valid) begin
                    if (bus.fb == ALL_MATCH) begin
                        w_next = S_DONE;
                        w_win  = 1'b1;
                    end else if (r_tries < 4'(MAX_TRIES)) begin
                        w_next  = S_GAP;
                        w_retry = 1'b1;
                    end else begin
                        w_next = S_FAIL;
                        w_lose = 1'b1;
                    end
                end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                    w_next   = S_FAIL;
                    w_lose   = 1'b1;
                    w_expire = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_probe = w_present && (r_state == S_ISSUE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_guess     <= '0;
            r_est       <= '0;
            r_gv        <= 1'b0;
            r_busy      <= 1'b0;
            r_solved    <= 1'b0;
            r_failed    <= 1'b0;
            r_timed_out <= 1'b0;
            r_tries     <= '0;
            r_won       <= '0;
            r_lost      <= '0;
            r_tcnt      <= '0;
        end else begin
            if (w_start_ok) begin
                r_solved    <= 1'b0;
                r_failed    <= 1'b0;
                r_timed_out <= 1'b0;
                r_busy      <= 1'b1;
                r_tries     <= '0;
            end
            if (w_present) begin
                r_guess <= w_probe ? w_lfsr : r_est;
                r_gv    <= 1'b1;
                r_tries <= r_tries + 4'd1;
                r_tcnt  <= '0;
            end else if (r_state == S_WAIT) begin
                r_tcnt <= r_tcnt + TW'(1);
            end
            // Matching bits keep the guess bit, mismatching bits flip it.
            if (w_retry) begin
                r_est <= r_guess ~^ bus.fb;
                r_gv  <= 1'b0;
            end
            if (w_win) begin
                r_gv     <= 1'b0;
                r_busy   <= 1'b0;
                r_solved <= 1'b1;
                if (r_won != 8'hFF) r_won <= r_won + 8'd1;
            end
            if (w_lose) begin
                r_gv        <= 1'b0;
                r_busy      <= 1'b0;
                r_failed    <= 1'b1;
                r_timed_out <= w_expire;
                if (r_lost != 8'hFF) r_lost <= r_lost + 8'd1;
            end
        end
    end

    assign bus.guess       = r_guess;
    assign bus.guess_valid = r_gv;
    assign o_busy          = r_busy;
    assign o_solved        = r_solved;
    assign o_failed        = r_failed;
    assign o_timed_out     = r_timed_out;
    assign o_tries         = r_tries;
    assign o_won_cnt       = r_won;
    assign o_lost_cnt      = r_lost;
    assign o_state         = r_state;

endmodule
